// File: rtl/gtxe2_chnl_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_sync_ctrl
//
// Receive-side synchronisation controller for a GTXE2-style channel. It
// enables comma alignment, waits for a run of clean aligned words, and then
// declares sync. Once in sync it uses a leaky error counter: errors raise the
// count, and long clean runs forgive errors. Loss of alignment, too many
// errors or electrical idle drop the link out of sync. If alignment never
// succeeds, the RX polarity is flipped on a timeout.
//
// Ports
//   clk               RX user clock (single clock domain)
//   rst_n             asynchronous active-low reset
//   rx_elecidle       electrical idle from the OOB detector (highest priority)
//   rx_byteisaligned  aligner lock status
//   rx_disperr[7:0]   per-byte disparity error, lanes >= BYTES ignored
//   rx_notintable[7:0] per-byte not-in-table flag, lanes >= BYTES ignored
//   rx_pcommaalignen  plus-comma align enable   (registered)
//   rx_mcommaalignen  minus-comma align enable  (registered)
//   rx_commadeten     comma detect enable       (registered)
//   rx_polarity       RX polarity invert        (registered)
//   sync_ok           link in sync              (registered)
//   state[1:0]        IDLE=0, ALIGN=1, SYNC=2   (registered)
//   loss_count[7:0]   saturating count of exits from SYNC
// ---------------------------------------------------------------------------
module gtxe2_chnl_rx_sync_ctrl #(
    parameter int BYTES         = 4,
    parameter int ACQ_CYCLES    = 4,
    parameter int ERR_LIMIT     = 4,
    parameter int GOOD_RUN      = 16,
    parameter int ALIGN_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_elecidle,
    input  logic       rx_byteisaligned,
    input  logic [7:0] rx_disperr,
    input  logic [7:0] rx_notintable,
    output logic       rx_pcommaalignen,
    output logic       rx_mcommaalignen,
    output logic       rx_commadeten,
    output logic       rx_polarity,
    output logic       sync_ok,
    output logic [1:0] state,
    output logic [7:0] loss_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SYNC  = 2'd2
    } state_t;

    localparam int AW = $clog2(ACQ_CYCLES + 1);
    localparam int TW = (ALIGN_TIMEOUT > 1) ? $clog2(ALIGN_TIMEOUT) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);

    localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(ALIGN_TIMEOUT - 1);
    localparam logic [EW-1:0] ERR_MAX   = EW'(ERR_LIMIT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_RUN - 1);
    localparam logic [7:0]    LANE_MASK = 8'((16'd1 << BYTES) - 16'd1);

    state_t        state_q, state_d;
    logic [AW-1:0] acq_q, acq_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [EW-1:0] errc_q, errc_d;
    logic [GW-1:0] good_q, good_d;
    logic          pol_d;
    logic [7:0]    loss_d;
    logic          err;
    logic          qual;

    // Only the active lanes contribute to the decoder error.
    assign err  = |((rx_disperr | rx_notintable) & LANE_MASK);
    assign qual = rx_byteisaligned & ~err;

    assign state = state_q;

    // Next-state and counter update. Entry/exit side effects are applied
    // after the per-state logic so every path into ALIGN or SYNC starts
    // with clean counters and every exit from SYNC is counted once.
    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        timer_d = timer_q;
        errc_d  = errc_q;
        good_d  = good_q;
        pol_d   = rx_polarity;
        loss_d  = loss_count;

        if (rx_elecidle) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ALIGN;
                end
                ST_ALIGN: begin
                    // Acquisition wins over a simultaneous timeout.
                    if (qual && acq_q == ACQ_LAST) begin
                        state_d = ST_SYNC;
                    end else if (timer_q == TMO_LAST) begin
                        pol_d   = ~rx_polarity;
                        timer_d = '0;
                        acq_d   = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                        acq_d   = qual ? acq_q + AW'(1) : '0;
                    end
                end
                ST_SYNC: begin
                    if (err) begin
                        errc_d = errc_q + EW'(1);
                        good_d = '0;
                        if (errc_d == ERR_MAX) begin
                            state_d = ST_ALIGN;
                        end
                    end else if (good_q == GOOD_LAST) begin
                        good_d = '0;
                        if (errc_q != '0) begin
                            errc_d = errc_q - EW'(1);
                        end
                    end else begin
                        good_d = good_q + GW'(1);
                    end
                    if (!rx_byteisaligned) begin
                        state_d = ST_ALIGN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (state_d == ST_ALIGN && state_q != ST_ALIGN) begin
            acq_d   = '0;
            timer_d = '0;
        end
        if (state_d == ST_SYNC && state_q != ST_SYNC) begin
            errc_d = '0;
            good_d = '0;
        end
        if (state_q == ST_SYNC && state_d != ST_SYNC && loss_count != 8'hFF) begin
            loss_d = loss_count + 8'd1;
        end
    end

    // Enables and sync_ok are decoded from the next state and registered,
    // so they always line up with the registered state output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            acq_q            <= '0;
            timer_q          <= '0;
            errc_q           <= '0;
            good_q           <= '0;
            rx_polarity      <= 1'b0;
            loss_count       <= 8'd0;
            rx_pcommaalignen <= 1'b0;
            rx_mcommaalignen <= 1'b0;
            rx_commadeten    <= 1'b0;
            sync_ok          <= 1'b0;
        end else begin
            state_q          <= state_d;
            acq_q            <= acq_d;
            timer_q          <= timer_d;
            errc_q           <= errc_d;
            good_q           <= good_d;
            rx_polarity      <= pol_d;
            loss_count       <= loss_d;
            rx_pcommaalignen <= (state_d == ST_ALIGN);
            rx_mcommaalignen <= (state_d == ST_ALIGN);
            rx_commadeten    <= (state_d != ST_IDLE);
            sync_ok          <= (state_d == ST_SYNC);
        end
    end

endmodule

// File: tb/tb_gtxe2_chnl_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gtxe2_chnl_rx_sync_ctrl
//
// Self-checking bench for gtxe2_chnl_rx_sync_ctrl, built with two active
// lanes so that the upper lanes can carry garbage that must be ignored.
// A cycle-level reference model tracks the link state, polarity and loss
// count from the documented rules; each scenario task compares the DUT
// outputs against the model and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_gtxe2_chnl_rx_sync_ctrl;

    localparam int BYTES = 2;
    localparam int ACQ   = 4;
    localparam int ERRL  = 4;
    localparam int GOOD  = 16;
    localparam int TMO   = 1024;
    localparam logic [7:0] LANE_MASK = 8'((16'd1 << BYTES) - 16'd1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_elecidle = 1'b1;
    logic       rx_byteisaligned = 1'b0;
    logic [7:0] rx_disperr = 8'd0;
    logic [7:0] rx_notintable = 8'd0;
    logic       rx_pcommaalignen, rx_mcommaalignen, rx_commadeten;
    logic       rx_polarity, sync_ok;
    logic [1:0] state;
    logic [7:0] loss_count;
    logic [14:0] obs;

    int n_checks = 0;
    int n_fail = 0;

    int m_state, m_acq, m_timer, m_errc, m_good, m_pol, m_loss;

    always #5 clk = ~clk;

    gtxe2_chnl_rx_sync_ctrl #(
        .BYTES(BYTES), .ACQ_CYCLES(ACQ), .ERR_LIMIT(ERRL),
        .GOOD_RUN(GOOD), .ALIGN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_elecidle(rx_elecidle), .rx_byteisaligned(rx_byteisaligned),
        .rx_disperr(rx_disperr), .rx_notintable(rx_notintable),
        .rx_pcommaalignen(rx_pcommaalignen), .rx_mcommaalignen(rx_mcommaalignen),
        .rx_commadeten(rx_commadeten), .rx_polarity(rx_polarity),
        .sync_ok(sync_ok), .state(state), .loss_count(loss_count)
    );

    assign obs = {rx_pcommaalignen, rx_mcommaalignen, rx_commadeten,
                  rx_polarity, sync_ok, state, loss_count};

    // Expected output vector from the model, same packing as obs.
    function automatic logic [14:0] exp_out();
        return {(m_state == 1), (m_state == 1), (m_state != 0),
                1'(m_pol), (m_state == 2), 2'(m_state), 8'(m_loss)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_acq = 0; m_timer = 0; m_errc = 0;
        m_good = 0; m_pol = 0; m_loss = 0;
    endtask

    // One clock of the link rules, using the inputs sampled at the edge.
    task automatic model_step();
        int e;
        e = (((rx_disperr | rx_notintable) & LANE_MASK) != 8'd0) ? 1 : 0;
        if (rx_elecidle) begin
            if (m_state == 2) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_acq = 0; m_timer = 0;
        end else if (m_state == 1) begin
            m_acq = (rx_byteisaligned && e == 0) ? m_acq + 1 : 0;
            if (m_acq == ACQ) begin
                m_state = 2; m_errc = 0; m_good = 0;
            end else if (m_timer == TMO - 1) begin
                m_pol = 1 - m_pol; m_timer = 0; m_acq = 0;
            end else begin
                m_timer++;
            end
        end else begin
            if (e != 0) begin
                m_errc++; m_good = 0;
            end else begin
                m_good++;
                if (m_good == GOOD) begin
                    m_good = 0;
                    if (m_errc > 0) m_errc--;
                end
            end
            if (m_errc == ERRL || !rx_byteisaligned) begin
                m_state = 1; m_acq = 0; m_timer = 0;
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            end
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clean_inputs();
        rx_disperr = 8'($urandom) & ~LANE_MASK;
        rx_notintable = 8'($urandom) & ~LANE_MASK;
    endtask

    task automatic error_inputs();
        logic [7:0] lane;
        lane = 8'(8'd1 << $urandom_range(BYTES - 1));
        clean_inputs();
        if ($urandom_range(1) == 1) rx_disperr = rx_disperr | lane;
        else rx_notintable = rx_notintable | lane;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_elecidle = 1'b1;
        #3;
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++; $display("[TB] FAIL reset_async: got %h expected %h", obs, 15'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++; $display("[TB] FAIL reset_held: got %h expected %h", obs, 15'd0);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (state !== 2'd0 || obs !== exp_out()) begin
            n_fail++; $display("[TB] FAIL idle_hold: got %h expected %h", obs, exp_out());
        end
    endtask

    task automatic test_acquisition();
        rx_elecidle = 1'b0;
        rx_byteisaligned = 1'b1;
        clean_inputs();
        step();
        n_checks++;
        if (state !== 2'd1 || {rx_pcommaalignen, rx_mcommaalignen, rx_commadeten} !== 3'b111
            || sync_ok !== 1'b0) begin
            n_fail++; $display("[TB] FAIL acq_enter_align: got %h expected state 1 enables 111", obs);
        end
        for (int i = 1; i < ACQ; i++) begin
            clean_inputs();
            step();
            n_checks++;
            if (state !== 2'd1 || obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL acq_wait_%0d: got %h expected %h", i, obs, exp_out());
            end
        end
        clean_inputs();
        step();
        n_checks++;
        if (state !== 2'd2 || sync_ok !== 1'b1
            || {rx_pcommaalignen, rx_mcommaalignen, rx_commadeten} !== 3'b001) begin
            n_fail++; $display("[TB] FAIL acq_sync: got %h expected state 2 sync 1 enables 001", obs);
        end
    endtask

    task automatic test_error_forgiveness();
        int loss0;
        loss0 = m_loss;
        for (int k = 0; k < 3; k++) begin
            error_inputs();
            step();
            for (int c = 0; c < GOOD; c++) begin
                clean_inputs();
                step();
            end
            n_checks++;
            if (state !== 2'd2 || loss_count !== 8'(loss0) || obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL forgive_%0d: got %h expected %h", k, obs, exp_out());
            end
        end
        for (int k = 0; k < ERRL; k++) begin
            error_inputs();
            step();
            n_checks++;
            if (obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL burst_%0d: got %h expected %h", k, obs, exp_out());
            end
        end
        n_checks++;
        if (state !== 2'd1 || loss_count !== 8'(loss0 + 1)) begin
            n_fail++; $display("[TB] FAIL burst_loss: got state %0d loss %0d expected state 1 loss %0d",
                               state, loss_count, loss0 + 1);
        end
    endtask

    task automatic test_lane_masking();
        rx_byteisaligned = 1'b1;
        repeat (ACQ) begin
            clean_inputs();
            step();
        end
        n_checks++;
        if (state !== 2'd2 || obs !== exp_out()) begin
            n_fail++; $display("[TB] FAIL mask_resync: got %h expected %h", obs, exp_out());
        end
        for (int i = 0; i < 20; i++) begin
            rx_disperr = 8'hFC;
            rx_notintable = 8'($urandom) & 8'hFC;
            step();
            n_checks++;
            if (sync_ok !== 1'b1 || obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL mask_%0d: got %h expected %h", i, obs, exp_out());
            end
        end
        clean_inputs();
    endtask

    task automatic test_polarity_timeout();
        logic pol0;
        rx_byteisaligned = 1'b0;
        step();
        pol0 = rx_polarity;
        n_checks++;
        if (state !== 2'd1 || obs !== exp_out()) begin
            n_fail++; $display("[TB] FAIL pto_enter: got %h expected %h", obs, exp_out());
        end
        for (int k = 1; k <= 2 * TMO; k++) begin
            clean_inputs();
            step();
            n_checks++;
            if (obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL pto_cycle_%0d: got %h expected %h", k, obs, exp_out());
            end
            if (k == TMO - 1 || k == TMO || k == 2 * TMO) begin
                n_checks++;
                if (rx_polarity !== (pol0 ^ (k >= TMO) ^ (k >= 2 * TMO)) || state !== 2'd1) begin
                    n_fail++; $display("[TB] FAIL pto_mark_%0d: got pol %b state %0d", k, rx_polarity, state);
                end
            end
        end
    endtask

    task automatic test_elecidle_saturation();
        int loss0;
        rx_byteisaligned = 1'b1;
        repeat (ACQ) begin
            clean_inputs();
            step();
        end
        loss0 = m_loss;
        rx_elecidle = 1'b1;
        step();
        n_checks++;
        if (state !== 2'd0 || loss_count !== 8'(loss0 + 1) || sync_ok !== 1'b0) begin
            n_fail++; $display("[TB] FAIL elecidle_exit: got state %0d loss %0d expected 0 and %0d",
                               state, loss_count, loss0 + 1);
        end
        for (int i = 0; i < 300; i++) begin
            rx_elecidle = 1'b0;
            rx_byteisaligned = 1'b1;
            clean_inputs();
            repeat (ACQ + 1) step();
            if ($urandom_range(1) == 1) rx_elecidle = 1'b1;
            else rx_byteisaligned = 1'b0;
            step();
            n_checks++;
            if (obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL sat_event_%0d: got %h expected %h", i, obs, exp_out());
            end
        end
        n_checks++;
        if (loss_count !== 8'd255) begin
            n_fail++; $display("[TB] FAIL loss_saturate: got %0d expected 255", loss_count);
        end
    endtask

    task automatic test_reset_mid_align();
        rx_elecidle = 1'b1;
        step();
        rx_elecidle = 1'b0;
        rx_byteisaligned = 1'b0;
        step();
        for (int i = 0; i < 2 * TMO && m_pol != 1; i++) step();
        n_checks++;
        if (rx_polarity !== 1'b1 || state !== 2'd1 || obs !== exp_out()) begin
            n_fail++; $display("[TB] FAIL pre_reset_align: got %h expected %h", obs, exp_out());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 15'd0) begin
            n_fail++; $display("[TB] FAIL reset_mid_align: got %h expected %h", obs, 15'd0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rx_elecidle = ($urandom_range(31) == 0);
            rx_byteisaligned = ($urandom_range(15) != 0);
            if ($urandom_range(7) == 0) begin
                rx_disperr = 8'($urandom);
                rx_notintable = 8'($urandom);
            end else begin
                clean_inputs();
            end
            step();
            n_checks++;
            if (obs !== exp_out()) begin
                n_fail++; $display("[TB] FAIL random_%0d: got %h expected %h", i, obs, exp_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acquisition();
        test_error_forgiveness();
        test_lane_masking();
        test_polarity_timeout();
        test_elecidle_saturation();
        test_reset_mid_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
